// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter_if
//  Description : Requester, shared-ALU and response signal bundle for
//                alu_arbiter. The slave modport is the arbiter side.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_arbiter_if #(
    parameter int DATA_W = 12
);
    logic              i_req0_valid;
    logic              o_req0_ready;
    logic [DATA_W-1:0] i_req0_a;
    logic [DATA_W-1:0] i_req0_b;
    logic [2:0]        i_req0_inst;

    logic              i_req1_valid;
    logic              o_req1_ready;
    logic [DATA_W-1:0] i_req1_a;
    logic [DATA_W-1:0] i_req1_b;
    logic [2:0]        i_req1_inst;

    logic              o_alu_valid;
    logic [DATA_W-1:0] o_alu_a;
    logic [DATA_W-1:0] o_alu_b;
    logic [2:0]        o_alu_inst;
    logic              i_alu_valid;
    logic [DATA_W-1:0] i_alu_data;
    logic              i_alu_overflow;

    logic              o_rsp_valid;
    logic              i_rsp_ready;
    logic              o_rsp_id;
    logic [DATA_W-1:0] o_rsp_data;
    logic              o_rsp_overflow;
    logic              o_rsp_timeout;

    modport slave (
        input  i_req0_valid, i_req0_a, i_req0_b, i_req0_inst,
        output o_req0_ready,
        input  i_req1_valid, i_req1_a, i_req1_b, i_req1_inst,
        output o_req1_ready,
        output o_alu_valid, o_alu_a, o_alu_b, o_alu_inst,
        input  i_alu_valid, i_alu_data, i_alu_overflow,
        output o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_overflow, o_rsp_timeout,
        input  i_rsp_ready
    );

    modport master (
        output i_req0_valid, i_req0_a, i_req0_b, i_req0_inst,
        input  o_req0_ready,
        output i_req1_valid, i_req1_a, i_req1_b, i_req1_inst,
        input  o_req1_ready,
        input  o_alu_valid, o_alu_a, o_alu_b, o_alu_inst,
        output i_alu_valid, i_alu_data, i_alu_overflow,
        input  o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_overflow, o_rsp_timeout,
        output i_rsp_ready
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Two-requester round-robin arbiter in front of a shared,
//                1-cycle-latency ALU; one transaction in flight, with timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_arbiter #(
    parameter int DATA_W  = 12,
    parameter int TIMEOUT = 4
) (
    input  wire logic    i_clk,
    input  wire logic    i_rst_n,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [3:0] c_CNT_LAST = 4'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              prio_q, prio_d;
    logic              id_q, id_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [2:0]        inst_q, inst_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_ovf_q, rsp_ovf_d;
    logic              rsp_to_q, rsp_to_d;

    logic              w_grant1;
    logic              w_req0_ready;
    logic              w_req1_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            prio_q     <= 1'b0;
            id_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            inst_q     <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_ovf_q  <= 1'b0;
            rsp_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            id_q       <= id_d;
            a_q        <= a_d;
            b_q        <= b_d;
            inst_q     <= inst_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_ovf_q  <= rsp_ovf_d;
            rsp_to_q   <= rsp_to_d;
        end
    end

    // prio_q = 1 means requester 1 wins when both are valid
    assign w_grant1 = bus.i_req1_valid && (!bus.i_req0_valid || prio_q);

    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        inst_d       = inst_q;
        cnt_d        = cnt_q;
        rsp_data_d   = rsp_data_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_to_d     = rsp_to_q;
        w_req0_ready = 1'b0;
        w_req1_ready = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.i_req0_valid || bus.i_req1_valid) begin
                    w_req0_ready = !w_grant1;
                    w_req1_ready = w_grant1;
                    id_d         = w_grant1;
                    a_d          = w_grant1 ? bus.i_req1_a    : bus.i_req0_a;
                    b_d          = w_grant1 ? bus.i_req1_b    : bus.i_req0_b;
                    inst_d       = w_grant1 ? bus.i_req1_inst : bus.i_req0_inst;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A result on the final wait cycle still beats the timeout
                if (bus.i_alu_valid) begin
                    rsp_data_d = bus.i_alu_data;
                    rsp_ovf_d  = bus.i_alu_overflow;
                    rsp_to_d   = 1'b0;
                    state_d    = S_RESP;
                end else if (cnt_q == c_CNT_LAST) begin
                    rsp_data_d = '0;
                    rsp_ovf_d  = 1'b0;
                    rsp_to_d   = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: begin
                if (bus.i_rsp_ready) begin
                    prio_d  = ~id_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Readies are combinational from the requesters, so mask them during reset
    assign bus.o_req0_ready   = w_req0_ready && i_rst_n;
    assign bus.o_req1_ready   = w_req1_ready && i_rst_n;

    assign bus.o_alu_valid    = (state_q == S_ISSUE);
    assign bus.o_alu_a        = a_q;
    assign bus.o_alu_b        = b_q;
    assign bus.o_alu_inst     = inst_q;

    assign bus.o_rsp_valid    = (state_q == S_RESP);
    assign bus.o_rsp_id       = id_q;
    assign bus.o_rsp_data     = rsp_data_q;
    assign bus.o_rsp_overflow = rsp_ovf_q;
    assign bus.o_rsp_timeout  = rsp_to_q;

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 12, is the operand and result width and SHALL match the ALU datapath.
REQ-002 Parameter TIMEOUT, default 4, is the maximum number of WAIT cycles for an ALU result (range 2..15).
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_req0_valid / o_req0_ready  in/out  1/1  requester 0 handshake.
REQ-006 i_req0_a, i_req0_b / i_req0_inst  input  DATA_W / 3  requester 0 operands and opcode.
REQ-007 i_req1_valid, o_req1_ready, i_req1_a, i_req1_b, i_req1_inst  same widths  requester 1, identical to requester 0.
REQ-008 o_alu_valid / o_alu_a / o_alu_b / o_alu_inst  output  1/DATA_W/DATA_W/3  drive to the shared ALU.
REQ-009 i_alu_valid / i_alu_data / i_alu_overflow  input  1/DATA_W/1  ALU registered result (1-cycle latency).
REQ-010 o_rsp_valid / i_rsp_ready  out/in  1/1  response handshake.
REQ-011 o_rsp_id / o_rsp_data / o_rsp_overflow / o_rsp_timeout  output  1/DATA_W/1/1  served requester, result, overflow flag, timeout flag.

Function
REQ-012 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; exactly one transaction in flight at any time.
REQ-013 IDLE: if any i_reqN_valid, grant one; o_reqN_ready SHALL be high combinationally in IDLE only for the granted N and low otherwise.
REQ-014 Grant: only one valid -> that one; both valid -> the requester holding priority; priority register SHALL point to req0 after reset.
REQ-015 On the accept cycle the arbiter SHALL register the granted a, b, inst and id, then enter ISSUE.
REQ-016 ISSUE: o_alu_valid SHALL be 1 for exactly one cycle with the registered operands; next state WAIT, timeout counter cleared.
REQ-017 o_alu_valid SHALL be 0 in every other state; o_alu_a/b/inst SHALL hold the last registered values.
REQ-018 WAIT: on i_alu_valid=1, capture i_alu_data and i_alu_overflow, o_rsp_timeout=0, go RESP.
REQ-019 WAIT: after TIMEOUT cycles without i_alu_valid, go RESP with o_rsp_data=0, o_rsp_overflow=0, o_rsp_timeout=1.
REQ-020 i_alu_valid outside WAIT SHALL be ignored; a late result does not alter a pending timeout response.
REQ-021 RESP: o_rsp_valid=1 with id/data/overflow/timeout held stable until i_rsp_ready=1; on that handshake return to IDLE and set priority to the non-served requester.
REQ-022 Backpressure: while o_rsp_valid=1 and i_rsp_ready=0, no new request SHALL be accepted (both readies low).
REQ-023 Minimum latency: accept in cycle T -> o_alu_valid in T+1 -> o_rsp_valid in T+3 (ALU result at T+2).
REQ-024 Throughput: back-to-back requests with i_rsp_ready=1 SHALL be accepted every 4 cycles.
REQ-025 Requests are never dropped: a requester holding valid without ready keeps its operands; arbiter samples only on the handshake cycle.

Reset
REQ-026 i_rst_n=0 SHALL immediately force state IDLE, priority to req0, counter 0, and all outputs to 0 (o_alu_*, o_rsp_*, o_reqN_ready).
REQ-027 Reset mid-transaction (any state) SHALL abandon the transaction without emitting a response; the first post-reset response belongs to a newly accepted request.

Verification
REQ-028 req0 valid, a=12'h005, b=12'h003, inst=3'b100, ALU model returns 12'hFF9 at T+2 -> o_req0_ready at T, o_alu_valid at T+1, o_rsp_valid at T+3 with id=0, data=12'hFF9, timeout=0.
REQ-029 Both requesters valid continuously, i_rsp_ready=1 -> grants alternate 0,1,0,1; responses every 4 cycles, ids match the grant order.
REQ-030 ALU model never asserts valid, TIMEOUT=4 -> o_rsp_valid with timeout=1, data=0 exactly TIMEOUT+2 cycles after accept; a later stray i_alu_valid is ignored.
REQ-031 i_rsp_ready=0 for 5 cycles during RESP -> response fields held stable, both readies low; response completes on the first ready=1 cycle.
REQ-032 i_rst_n pulsed low during WAIT -> outputs 0 immediately, no response emitted, next request granted to req0 when both are valid.
REQ-033 ALU model returns overflow=1, data=12'h800 -> o_rsp_overflow=1, o_rsp_data=12'h800 for the correct id.
